// File: rtl/tb_rice_core_env_pipeline_tracker.sv
// tb_rice_core_env_pipeline_tracker: fetch-bus outstanding tracker and pipeline occupancy/retire monitor
module tb_rice_core_env_pipeline_tracker #(
  parameter int XLEN = 32,
  parameter int STAGES = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_DEPTH = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int RETIRE_WIDTH = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_request_valid,
  input  logic                                 i_request_ready,
  input  logic [XLEN-1:0]                      i_request_address,
  input  logic                                 i_response_valid,
  input  logic                                 i_if_valid,
  input  logic                                 i_stall,
  input  logic                                 i_flush,
  output logic                                 o_request_issued,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding_count,
  output logic                                 o_pending_valid,
  output logic [XLEN-1:0]                      o_pending_address,
  output logic                                 o_response_stale,
  output logic [STAGES-1:0]                    o_stage_valid,
  output logic                                 o_flush_d,
  output logic [RETIRE_WIDTH-1:0]              o_retire_count,
  output logic [2:0]                           o_error
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  logic ack, push, pop, full, empty;
  logic [PW-1:0] head, tail;
  logic [XLEN-1:0] mem [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] stale;
  logic [XLEN-1:0] cap_addr;
  logic [STAGES-1:1] stage_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  assign ack = i_request_valid && i_request_ready;
  assign empty = o_outstanding_count == '0;
  assign full = o_outstanding_count == CW'(MAX_OUTSTANDING);
  assign pop = i_response_valid && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push = ack && (!full || pop);
  assign o_pending_valid = !empty;
  assign o_pending_address = mem[head];
  assign o_response_stale = i_response_valid && o_pending_valid && stale[head];
  assign o_stage_valid = {stage_q, i_if_valid && !i_stall};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_request_issued <= 1'b0;
      o_outstanding_count <= '0;
      o_flush_d <= 1'b0;
      o_retire_count <= '0;
      o_error <= '0;
      head <= '0;
      tail <= '0;
      stale <= '0;
      cap_addr <= '0;
      stage_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) mem[i] <= '0;
    end else begin
      o_request_issued <= ack ? 1'b0 : (o_request_issued || i_request_valid);
      if (!o_request_issued && i_request_valid && !ack) cap_addr <= i_request_address;
      if (o_request_issued && (!i_request_valid || i_request_address != cap_addr)) o_error[0] <= 1'b1;
      if (ack && full && !pop) o_error[1] <= 1'b1;
      if (i_response_valid && empty) o_error[2] <= 1'b1;
      // empty slots are marked too; a push always clears its own slot, so only pre-edge entries stay stale
      if (i_flush) stale <= '1;
      if (push) begin
        mem[tail] <= i_request_address;
        stale[tail] <= 1'b0;
        tail <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      o_outstanding_count <= o_outstanding_count + CW'(push) - CW'(pop);
      o_flush_d <= i_flush;
      for (int k = 1; k < STAGES; k++)
        stage_q[k] <= (k == 1 ? i_if_valid : o_stage_valid[k-1]) && !(i_stall && k <= STALL_DEPTH) && !(i_flush && k <= FLUSH_DEPTH);
      if (o_stage_valid[STAGES-1] && o_retire_count != '1) o_retire_count <= o_retire_count + 1'b1;
    end
endmodule

// File: tb/tb_tb_rice_core_env_pipeline_tracker.sv
// tb_tb_rice_core_env_pipeline_tracker: scoreboard bench for the fetch/pipeline tracker (two FIFO depths)
module tb_tb_rice_core_env_pipeline_tracker;
  logic clk = 0, rst_n = 0, rv = 0, rr = 0, resp = 0, ifv = 0, stall = 0, flush = 0;
  logic [31:0] ra = '0;
  logic a_issued, a_pv, a_stale, a_fd, b_issued, b_pv, b_stale, b_fd;
  logic [1:0] a_cnt;
  logic [2:0] b_cnt, a_err, b_err;
  logic [31:0] a_pa, b_pa;
  logic [3:0] a_sv, b_sv, a_ret, b_ret;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] addr; logic stale;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [3:0] sv_tab [12] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1000, 4'b0011,
                              4'b0111, 4'b1111, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
  logic [3:0] rt_tab [12] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6};

  always #5 clk = ~clk;

  tb_rice_core_env_pipeline_tracker #(.MAX_OUTSTANDING(2), .RETIRE_WIDTH(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_request_valid(rv), .i_request_ready(rr),
    .i_request_address(ra), .i_response_valid(resp), .i_if_valid(ifv), .i_stall(stall),
    .i_flush(flush), .o_request_issued(a_issued), .o_outstanding_count(a_cnt),
    .o_pending_valid(a_pv), .o_pending_address(a_pa), .o_response_stale(a_stale),
    .o_stage_valid(a_sv), .o_flush_d(a_fd), .o_retire_count(a_ret), .o_error(a_err));

  tb_rice_core_env_pipeline_tracker #(.MAX_OUTSTANDING(4), .RETIRE_WIDTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_request_valid(rv), .i_request_ready(rr),
    .i_request_address(ra), .i_response_valid(resp), .i_if_valid(ifv), .i_stall(stall),
    .i_flush(flush), .o_request_issued(b_issued), .o_outstanding_count(b_cnt),
    .o_pending_valid(b_pv), .o_pending_address(b_pa), .o_response_stale(b_stale),
    .o_stage_valid(b_sv), .o_flush_d(b_fd), .o_retire_count(b_ret), .o_error(b_err));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_issued"}, 64'(a_issued), 64'd0);
    chk({tag, "_count"}, 64'(a_cnt), 64'd0);
    chk({tag, "_pending"}, 64'({a_pv, a_pa}), 64'd0);
    chk({tag, "_stale"}, 64'(a_stale), 64'd0);
    chk({tag, "_stage"}, 64'(a_sv), 64'({3'b000, ifv && !stall}));
    chk({tag, "_flush_d"}, 64'(a_fd), 64'd0);
    chk({tag, "_retire"}, 64'(a_ret), 64'd0);
    chk({tag, "_error"}, 64'(a_err), 64'd0);
  endtask

  task automatic exp_both(input logic [31:0] addr, input logic st);
    qa.push_back('{addr, st});
    qb.push_back('{addr, st});
  endtask

  always @(negedge clk)
    if (rst_n && resp && a_pv) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_resp: unexpected response, head %0h stale %0b, none expected", a_pa, a_stale);
      end else begin
        ea = qa.pop_front();
        if (a_pa !== ea.addr || a_stale !== ea.stale) begin
          errors++;
          $display("FAIL a_resp: got addr %0h stale %0b expected addr %0h stale %0b", a_pa, a_stale, ea.addr, ea.stale);
        end
      end
    end

  always @(negedge clk)
    if (rst_n && resp && b_pv) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_resp: unexpected response, head %0h stale %0b, none expected", b_pa, b_stale);
      end else begin
        eb = qb.pop_front();
        if (b_pa !== eb.addr || b_stale !== eb.stale) begin
          errors++;
          $display("FAIL b_resp: got addr %0h stale %0b expected addr %0h stale %0b", b_pa, b_stale, eb.addr, eb.stale);
        end
      end
    end

  initial begin
    #3;
    chk_idle("reset");
    #9 rst_n = 1;
    // back-to-back fetches with overlapping responses
    exp_both(32'h0, 1'b0);
    exp_both(32'h4, 1'b0);
    exp_both(32'h8, 1'b0);
    rv = 1; rr = 1; ra = 32'h0;
    tick(); chk("b2b_cnt0", 64'(a_cnt), 64'd1);
    ra = 32'h4;
    tick(); chk("b2b_cnt1", 64'(a_cnt), 64'd2);
    ra = 32'h8; resp = 1;
    tick(); chk("b2b_cnt2", 64'(a_cnt), 64'd2);
    rv = 0; rr = 0; ra = 32'h0;
    tick(); chk("b2b_cnt3", 64'(a_cnt), 64'd1);
    tick(); chk("b2b_cnt4", 64'(a_cnt), 64'd0);
    resp = 0;
    chk("b2b_error", 64'(a_err), 64'd0);
    // flush with two pending; depth-2 copy overflows, depth-4 copy accepts 0x100
    qa.push_back('{32'h10, 1'b1});
    qa.push_back('{32'h14, 1'b1});
    qb.push_back('{32'h10, 1'b1});
    qb.push_back('{32'h14, 1'b1});
    qb.push_back('{32'h100, 1'b0});
    rv = 1; rr = 1; ra = 32'h10;
    tick();
    ra = 32'h14;
    tick(); chk("fl_cnt_pre", 64'(a_cnt), 64'd2);
    ra = 32'h100; flush = 1;
    tick();
    chk("ovf_cnt", 64'(a_cnt), 64'd2);
    chk("ovf_error", 64'(a_err), 64'd2);
    chk("fl_b_cnt", 64'(b_cnt), 64'd3);
    chk("fl_flush_d_hi", 64'(a_fd), 64'd1);
    rv = 0; rr = 0; ra = 32'h0; flush = 0;
    tick(); chk("fl_flush_d_lo", 64'(a_fd), 64'd0);
    resp = 1;
    tick(); tick(); tick();
    resp = 0;
    chk("udf_cnt", 64'(a_cnt), 64'd0);
    chk("udf_error", 64'(a_err), 64'd6);
    chk("fl_b_cnt_end", 64'(b_cnt), 64'd0);
    chk("fl_b_error", 64'(b_err), 64'd0);
    rst_n = 0; #2 rst_n = 1;
    chk("pulse_error", 64'(a_err), 64'd0);
    // address changes while a request waits for ready
    rv = 1; rr = 0; ra = 32'h40;
    tick();
    chk("prot_issued", 64'(a_issued), 64'd1);
    chk("prot_err_pre", 64'(a_err), 64'd0);
    ra = 32'h44;
    tick(); chk("prot_error", 64'(a_err), 64'd1);
    rv = 0; ra = 32'h0;
    // stage bubbles from one stall cycle then one flush cycle
    ifv = 1;
    for (int i = 0; i < 12; i++) begin
      stall = (i == 4);
      flush = (i == 8);
      tick();
      chk($sformatf("stage_%0d", i), 64'(a_sv), 64'(sv_tab[i]));
      chk($sformatf("retire_%0d", i), 64'(a_ret), 64'(rt_tab[i]));
    end
    stall = 0; flush = 0;
    repeat (20) tick();
    chk("retire_sat", 64'(a_ret), 64'd15);
    #3 rst_n = 0;
    #1 chk_idle("midreset");
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
